// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, the fetch-queue entry layout and small helpers.
package mips32_pkg;

  localparam int IMEM_AW = 10;

  localparam logic [5:0] HLT   = 6'b111111;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] ADDI  = 6'b001010;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

  function automatic logic is_hlt(input logic [31:0] ir);
    return (ir[31:26] == HLT);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hffff_ffff : sum[31:0];
  endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; pointers wrap naturally, count is one bit wider.
module mips32_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flush overrides both push and pop so a redirect never leaves a partial update behind.
  always_comb begin
    push_ok_s = push && !flush;
    pop_ok_s  = pop && !flush && (count_r != '0);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + (PW+1)'(push_ok_s) - (PW+1)'(pop_ok_s);
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = (count_r == '0);
  assign count    = count_r;

  mips32_sync_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .count (count_r)
  );

endmodule

// Overflow/underflow checks for mips32_sync_fifo.
module mips32_sync_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   push,
  input logic                   pop,
  input logic                   flush,
  input logic [$clog2(DEPTH):0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && !pop && (32'(count) == DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(pop && (count == '0)));

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: PC, imem request credit, {IR,NPC} queue to decode.
// Optional counters are enabled with `define FETCH_QUEUE_STATS_EN.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = IMEM_AW,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_npc,
  output logic          halted
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_flushed,
  output logic [31:0]   stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]  pc_r;
  logic [31:0]  tag_r;
  logic         pending_r;
  logic         drop_r;
  logic         halted_r;

  logic [PW:0]  count_s;
  logic         empty_s;
  logic [63:0]  pop_data_s;
  fetch_entry_t head_s;
  fetch_entry_t push_entry_s;
  logic         issue_s;
  logic         resp_s;
  logic         push_s;
  logic         out_valid_s;
  logic         pop_s;

  // Issue credit counts the in-flight word so a response always has a free slot.
  always_comb begin
    issue_s      = !rst && !halted_r && !redirect_valid &&
                   ((32'(count_s) + 32'(pending_r)) < 32'(DEPTH));
    resp_s       = pending_r && !drop_r && !halted_r;
    push_s       = resp_s && !redirect_valid && !rst;
    out_valid_s  = !empty_s && !redirect_valid;
    pop_s        = out_valid_s && out_ready;
    push_entry_s = '{ir: mem_rdata, npc: tag_r + 32'd1};
    head_s       = fetch_entry_t'(pop_data_s);
  end

  // PC, in-flight tracking and halt state; redirect takes priority over everything else.
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      tag_r     <= 32'h0;
      pending_r <= 1'b0;
      drop_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      pending_r <= issue_s;
      if (redirect_valid) begin
        pc_r     <= redirect_pc;
        halted_r <= 1'b0;
        drop_r   <= pending_r;
      end else begin
        drop_r <= 1'b0;
        if (issue_s) begin
          tag_r <= pc_r;
          pc_r  <= pc_r + 32'd1;
        end
        if (push_s && is_hlt(mem_rdata)) begin
          halted_r <= 1'b1;
        end
      end
    end
  end

  mips32_sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clk       (clk1),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .pop_data  (pop_data_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign mem_req   = issue_s;
  assign mem_addr  = pc_r[AW-1:0];
  assign out_valid = out_valid_s;
  assign out_ir    = empty_s ? 32'h0 : head_s.ir;
  assign out_npc   = empty_s ? 32'h0 : head_s.npc;
  assign halted    = halted_r;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_flushed_r;
  logic [31:0] stat_stall_r;

  // Saturating event counters; a flush counts queued entries plus the response it kills.
  always_ff @(posedge clk1) begin
    if (rst) begin
      stat_fetched_r <= 32'h0;
      stat_flushed_r <= 32'h0;
      stat_stall_r   <= 32'h0;
    end else begin
      if (push_s) begin
        stat_fetched_r <= sat_add(stat_fetched_r, 32'd1);
      end
      if (redirect_valid) begin
        stat_flushed_r <= sat_add(stat_flushed_r, 32'(count_s) + 32'(resp_s));
      end
      if (out_valid_s && !out_ready) begin
        stat_stall_r <= sat_add(stat_stall_r, 32'd1);
      end
    end
  end

  assign stat_fetched = stat_fetched_r;
  assign stat_flushed = stat_flushed_r;
  assign stat_stall   = stat_stall_r;
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed self-checking bench for mips32_fetch_queue with a 1-cycle-latency instruction memory.
module tb_mips32_fetch_queue;

  logic        clk1;
  logic        rst;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic        halted;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
  logic [31:0] stat_stall;
`endif

  logic [31:0] imem [16];
  int pass_cnt = 0;
  int total_cnt = 0;

  mips32_fetch_queue dut (
    .clk1           (clk1),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_npc        (out_npc),
    .halted         (halted)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed),
    .stat_stall     (stat_stall)
`endif
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    mem_rdata <= mem_req ? imem[mem_addr[3:0]] : 32'hdead_beef;
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) imem[i] = 32'h2800_0000 + 32'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_seq();
    out_ready = 1'b1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%0b exp=0", mem_req); else pass_cnt++;
    total_cnt++; if (out_ir !== 32'h0) $display("FAIL reset_out_ir got=%h exp=0", out_ir); else pass_cnt++;
    total_cnt++; if (out_npc !== 32'h0) $display("FAIL reset_out_npc got=%h exp=0", out_npc); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", halted); else pass_cnt++;
    total_cnt++; if (mem_addr !== 10'd0) $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_ir [4];
    int pops;
    fill_seq();
    imem[0] = 32'h2801_000a; imem[1] = 32'h2802_0014;
    imem[2] = 32'h2803_0019; imem[3] = 32'hfc00_0000;
    for (int i = 0; i < 4; i++) exp_ir[i] = imem[i];
    out_ready = 1'b1;
    do_reset();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_first_gap out_valid=%0b exp=0", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_first_valid out_valid=%0b exp=1", out_valid); else pass_cnt++;
    pops = 0;
    for (int c = 0; c < 14; c++) begin
      if (out_valid && out_ready) begin
        if (pops < 4) begin
          total_cnt++; if (out_npc !== 32'(pops + 1)) $display("FAIL stream_npc got=%0d exp=%0d", out_npc, pops + 1); else pass_cnt++;
          total_cnt++; if (out_ir !== exp_ir[pops]) $display("FAIL stream_ir got=%h exp=%h", out_ir, exp_ir[pops]); else pass_cnt++;
        end
        pops++;
      end
      step();
    end
    total_cnt++; if (pops !== 4) $display("FAIL stream_pop_count got=%0d exp=4", pops); else pass_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL stream_halted got=%0b exp=1", halted); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL stream_halt_no_req got=%0b exp=0", mem_req); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    fill_seq();
    out_ready = 1'b0;
    do_reset();
    repeat (10) step();
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL bp_full_no_req got=%0b exp=0", mem_req); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_full_valid got=%0b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_npc !== 32'd1) $display("FAIL bp_head_npc got=%0d exp=1", out_npc); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_drain_gap k=%0d out_valid=%0b exp=1", k, out_valid); else pass_cnt++;
      total_cnt++; if (out_npc !== 32'(k + 1)) $display("FAIL bp_drain_npc got=%0d exp=%0d", out_npc, k + 1); else pass_cnt++;
      total_cnt++; if (out_ir !== imem[k]) $display("FAIL bp_drain_ir got=%h exp=%h", out_ir, imem[k]); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_redirect();
    int w;
    fill_seq();
    out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL redir_no_req got=%0b exp=0", mem_req); else pass_cnt++;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_flushed got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL redir_req got=%0b exp=1", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 10'd5) $display("FAIL redir_addr got=%0d exp=5", mem_addr); else pass_cnt++;
`ifdef FETCH_QUEUE_STATS_EN
    total_cnt++; if (stat_flushed !== 32'd4) $display("FAIL stat_flushed got=%0d exp=4", stat_flushed); else pass_cnt++;
`endif
    w = 0;
    while (!out_valid && w < 10) begin
      step();
      w++;
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL redir_timeout out_valid=%0b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_npc !== 32'd6) $display("FAIL redir_npc got=%0d exp=6", out_npc); else pass_cnt++;
    total_cnt++; if (out_ir !== imem[5]) $display("FAIL redir_ir got=%h exp=%h", out_ir, imem[5]); else pass_cnt++;
    step();
    total_cnt++; if (out_npc !== 32'd7) $display("FAIL redir_next_npc got=%0d exp=7", out_npc); else pass_cnt++;
  endtask

  task automatic test_hlt_squash();
    int w;
    fill_seq();
    imem[9] = 32'hfc00_0000;
    out_ready = 1'b1;
    do_reset();
    repeat (10) step();
    total_cnt++; if (halted !== 1'b0) $display("FAIL hlt_before got=%0b exp=0", halted); else pass_cnt++;
    step();
    total_cnt++; if (halted !== 1'b1) $display("FAIL hlt_set got=%0b exp=1", halted); else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL hlt_redir_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    step();
    redirect_valid = 1'b0;
    #1;
    total_cnt++; if (halted !== 1'b0) $display("FAIL hlt_cleared got=%0b exp=0", halted); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 10'd5) $display("FAIL hlt_resume req=%0b addr=%0d exp=1/5", mem_req, mem_addr); else pass_cnt++;
    w = 0;
    while (!out_valid && w < 10) begin
      step();
      w++;
    end
    total_cnt++; if (out_npc !== 32'd6 || out_ir !== imem[5]) $display("FAIL hlt_resume_head npc=%0d ir=%h exp=6/%h", out_npc, out_ir, imem[5]); else pass_cnt++;
  endtask

  task automatic test_midrun_reset();
    fill_seq();
    out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (mem_addr !== 10'd0) $display("FAIL mrst_addr got=%0d exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL mrst_req got=%0b exp=1", mem_req); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_drop got=%0b exp=0", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_npc !== 32'd1 || out_ir !== imem[0]) $display("FAIL mrst_first valid=%0b npc=%0d ir=%h exp=1/1/%h", out_valid, out_npc, out_ir, imem[0]); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_hlt_squash();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
